memory_unit: RTL and testbench

- Pipeline stage directly downstream of the execute stage, upstream of writeback.
- Takes the execute result register and performs LOAD/STORE transactions on a single-beat, 64-bit data bus.
  - Stores: byte-lane placement and byte enables.
  - Loads: extraction and sign/zero extension.
- Non-memory ops pass through unchanged.
- Uses a valid/ready handshake on both pipeline sides so bus wait states stall the pipe.

---
 rtl/memory_unit.sv | 181 ++++++++++++++++++
 tb/tb_memory_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : memory_unit (with isa package)                         |
// | Description : Memory pipeline stage between execute and writeback.   |
// |               Performs LOAD/STORE on a single-beat 64-bit bus with   |
// |               byte-lane placement, byte enables, load extraction and |
// |               sign/zero extension; other ops pass straight through.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

package isa;
  localparam int XLEN     = 64;
  localparam int RCNT_LOG = 5;
  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;
  localparam opcode_t OPC_LOAD  = 7'b0000011;
  localparam opcode_t OPC_STORE = 7'b0100011;
  localparam opcode_t OPC_OP    = 7'b0110011;
endpackage

module memory_unit
  import isa::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                src_valid,
  output logic                src_ready,
  input  opcode_t             src_opcode,
  input  funct3_t             src_funct3,
  input  logic [RCNT_LOG-1:0] src_rd_addr,
  input  logic [XLEN-1:0]     src_rd,
  input  logic [XLEN-1:0]     src_mem_addr,
  input  logic [XLEN-1:0]     src_mem_wr_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [7:0]          mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                dst_valid,
  input  logic                dst_ready,
  output opcode_t             dst_opcode,
  output logic [RCNT_LOG-1:0] dst_rd_addr,
  output logic [XLEN-1:0]     dst_rd,
  output logic                dst_fault
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t          state;
  funct3_t         pend_funct3;   // access size/sign of the op on the bus
  logic [2:0]      pend_off;      // byte offset of the op on the bus
  logic            pend_load;

  logic            accept;
  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic [2:0]      off;
  logic            misaligned;
  logic            illegal;
  logic            fault_req;
  logic [7:0]      size_mask;
  logic [7:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  // The stage accepts only in IDLE and only when the dst register is free
  // (or being drained this cycle), so a result is never overwritten.
  assign src_ready = (state == IDLE) && (!dst_valid || dst_ready);
  assign accept    = src_valid && src_ready;

  // Decode the incoming op: alignment/legality and bus lane placement.
  always_comb begin
    is_load    = (src_opcode == OPC_LOAD);
    is_store   = (src_opcode == OPC_STORE);
    is_mem     = is_load || is_store;
    off        = src_mem_addr[2:0];
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (src_funct3[1:0])
      2'd0: begin misaligned = 1'b0;         size_mask = 8'h01; end
      2'd1: begin misaligned = off[0];       size_mask = 8'h03; end
      2'd2: begin misaligned = |off[1:0];    size_mask = 8'h0F; end
      default: begin misaligned = |off;      size_mask = 8'hFF; end
    endcase
    illegal    = (is_load && (src_funct3 == 3'b111)) || (is_store && src_funct3[2]);
    fault_req  = is_mem && (misaligned || illegal);
    be_next    = size_mask << off;
    wdata_next = is_store ? (src_mem_wr_data << {off, 3'b000}) : '0;
  end

  // Right-align the returned doubleword and extend to the access size.
  always_comb begin
    shifted   = mem_rdata >> {pend_off, 3'b000};
    load_data = '0;
    if (pend_load) begin
      case (pend_funct3)
        3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
        3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
        3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
        3'b011:  load_data = shifted;
        3'b100:  load_data = {56'd0, shifted[7:0]};
        3'b101:  load_data = {48'd0, shifted[15:0]};
        3'b110:  load_data = {32'd0, shifted[31:0]};
        default: load_data = '0;
      endcase
    end
  end

  // Stage FSM: IDLE accepts ops, BUS holds the request until mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      dst_valid   <= 1'b0;
      dst_fault   <= 1'b0;
      dst_rd      <= '0;
      dst_rd_addr <= '0;
      dst_opcode  <= '0;
      pend_funct3 <= '0;
      pend_off    <= '0;
      pend_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dst_ready) dst_valid <= 1'b0;
          if (accept) begin
            // dst is free here, so its tag fields may be loaded right away.
            dst_opcode  <= src_opcode;
            dst_rd_addr <= src_rd_addr;
            if (!is_mem) begin
              dst_valid <= 1'b1;
              dst_fault <= 1'b0;
              dst_rd    <= src_rd;
            end else if (fault_req) begin
              dst_valid <= 1'b1;
              dst_fault <= 1'b1;
              dst_rd    <= '0;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= {src_mem_addr[XLEN-1:3], 3'b000};
              mem_be      <= be_next;
              mem_wdata   <= wdata_next;
              pend_funct3 <= src_funct3;
              pend_off    <= off;
              pend_load   <= is_load;
              state       <= BUS;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            dst_valid <= 1'b1;
            dst_fault <= 1'b0;
            dst_rd    <= load_data;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_memory_unit                                         |
// | Description : Self-checking bench for memory_unit: vector table of   |
// |               single memory ops plus hand sequences for pass-through,|
// |               backpressure and reset during a bus transaction.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_memory_unit;
  import isa::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                src_valid;
  logic                src_ready;
  opcode_t             src_opcode;
  funct3_t             src_funct3;
  logic [RCNT_LOG-1:0] src_rd_addr;
  logic [XLEN-1:0]     src_rd;
  logic [XLEN-1:0]     src_mem_addr;
  logic [XLEN-1:0]     src_mem_wr_data;
  logic                mem_req;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [7:0]          mem_be;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;
  logic                dst_valid;
  logic                dst_ready;
  opcode_t             dst_opcode;
  logic [RCNT_LOG-1:0] dst_rd_addr;
  logic [XLEN-1:0]     dst_rd;
  logic                dst_fault;

  int compared   = 0;
  int mismatched = 0;

  memory_unit dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_opcode(src_opcode), .src_funct3(src_funct3),
    .src_rd_addr(src_rd_addr), .src_rd(src_rd),
    .src_mem_addr(src_mem_addr), .src_mem_wr_data(src_mem_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dst_valid(dst_valid), .dst_ready(dst_ready),
    .dst_opcode(dst_opcode), .dst_rd_addr(dst_rd_addr),
    .dst_rd(dst_rd), .dst_fault(dst_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    opcode_t    opcode;
    funct3_t    funct3;
    logic [4:0] rd_addr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    logic        fault;
    logic [63:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic        exp_we;
    logic [63:0] exp_rd;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];
  localparam logic [63:0] RD = 64'h80FF00007F000000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    src_valid = 1'b0; src_opcode = OPC_OP; src_funct3 = '0; src_rd_addr = '0;
    src_rd = '0; src_mem_addr = '0; src_mem_wr_data = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    dst_ready = 1'b1;
    src_valid = 1'b1; src_opcode = v.opcode; src_funct3 = v.funct3;
    src_rd_addr = v.rd_addr; src_rd = 64'hDEAD; src_mem_addr = v.addr;
    src_mem_wr_data = v.wdata;
    #1 chk($sformatf("v%0d.src_ready", i), {63'd0, src_ready}, 64'd1);
    @(negedge clk);
    drive_idle();
    if (v.fault) begin
      chk($sformatf("v%0d.mem_req", i), {63'd0, mem_req}, 64'd0);
      chk($sformatf("v%0d.dst_valid", i), {63'd0, dst_valid}, 64'd1);
      chk($sformatf("v%0d.dst_fault", i), {63'd0, dst_fault}, 64'd1);
      chk($sformatf("v%0d.dst_rd", i), dst_rd, 64'd0);
    end else begin
      chk($sformatf("v%0d.mem_req", i), {63'd0, mem_req}, 64'd1);
      chk($sformatf("v%0d.mem_we", i), {63'd0, mem_we}, {63'd0, v.exp_we});
      chk($sformatf("v%0d.mem_addr", i), mem_addr, v.exp_addr);
      chk($sformatf("v%0d.mem_be", i), {56'd0, mem_be}, {56'd0, v.exp_be});
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.exp_wdata);
      chk($sformatf("v%0d.dst_valid_bus", i), {63'd0, dst_valid}, 64'd0);
      chk($sformatf("v%0d.src_ready_bus", i), {63'd0, src_ready}, 64'd0);
      for (int w = 0; w < v.waits; w++) begin
        @(negedge clk);
        chk($sformatf("v%0d.hold_req%0d", i, w), {63'd0, mem_req}, 64'd1);
        chk($sformatf("v%0d.hold_be%0d", i, w), {56'd0, mem_be}, {56'd0, v.exp_be});
        chk($sformatf("v%0d.hold_wdata%0d", i, w), mem_wdata, v.exp_wdata);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      chk($sformatf("v%0d.req_drop", i), {63'd0, mem_req}, 64'd0);
      chk($sformatf("v%0d.dst_valid", i), {63'd0, dst_valid}, 64'd1);
      chk($sformatf("v%0d.dst_fault", i), {63'd0, dst_fault}, 64'd0);
      chk($sformatf("v%0d.dst_rd", i), dst_rd, v.exp_rd);
    end
    chk($sformatf("v%0d.dst_rd_addr", i), {59'd0, dst_rd_addr}, {59'd0, v.rd_addr});
    chk($sformatf("v%0d.dst_opcode", i), {57'd0, dst_opcode}, {57'd0, v.opcode});
  endtask

  initial begin
    //            opc        f3      rd     addr          wdata                  rdata  wt flt exp_addr      be     exp_wdata              we    exp_rd
    vecs[0]  = '{OPC_STORE, 3'b000, 5'd1,  64'h1003, 64'hAB,                 64'h0, 3, 1'b0, 64'h1000, 8'h08, 64'h00000000AB000000, 1'b1, 64'h0};
    vecs[1]  = '{OPC_LOAD,  3'b000, 5'd2,  64'h2007, 64'h0,                  RD,    1, 1'b0, 64'h2000, 8'h80, 64'h0,                1'b0, 64'hFFFFFFFFFFFFFF80};
    vecs[2]  = '{OPC_LOAD,  3'b100, 5'd3,  64'h2007, 64'h0,                  RD,    0, 1'b0, 64'h2000, 8'h80, 64'h0,                1'b0, 64'h80};
    vecs[3]  = '{OPC_LOAD,  3'b001, 5'd4,  64'h2006, 64'h0,                  RD,    0, 1'b0, 64'h2000, 8'hC0, 64'h0,                1'b0, 64'hFFFFFFFFFFFF80FF};
    vecs[4]  = '{OPC_LOAD,  3'b010, 5'd5,  64'h2004, 64'h0,                  RD,    2, 1'b0, 64'h2000, 8'hF0, 64'h0,                1'b0, 64'hFFFFFFFF80FF0000};
    vecs[5]  = '{OPC_LOAD,  3'b110, 5'd6,  64'h2004, 64'h0,                  RD,    0, 1'b0, 64'h2000, 8'hF0, 64'h0,                1'b0, 64'h0000000080FF0000};
    vecs[6]  = '{OPC_LOAD,  3'b101, 5'd7,  64'h2006, 64'h0,                  RD,    0, 1'b0, 64'h2000, 8'hC0, 64'h0,                1'b0, 64'h00000000000080FF};
    vecs[7]  = '{OPC_LOAD,  3'b011, 5'd0,  64'h2000, 64'h0,                  RD,    1, 1'b0, 64'h2000, 8'hFF, 64'h0,                1'b0, RD};
    vecs[8]  = '{OPC_LOAD,  3'b010, 5'd8,  64'h2000, 64'h0,                  RD,    0, 1'b0, 64'h2000, 8'h0F, 64'h0,                1'b0, 64'h000000007F000000};
    vecs[9]  = '{OPC_STORE, 3'b011, 5'd9,  64'h3000, 64'h1122334455667788,   64'h0, 0, 1'b0, 64'h3000, 8'hFF, 64'h1122334455667788, 1'b1, 64'h0};
    vecs[10] = '{OPC_STORE, 3'b001, 5'd10, 64'h3002, 64'hFFFFFFFFFFFFBEEF,   64'h0, 1, 1'b0, 64'h3000, 8'h0C, 64'hFFFFFFFFBEEF0000, 1'b1, 64'h0};
    vecs[11] = '{OPC_STORE, 3'b010, 5'd11, 64'h1004, 64'hDEADBEEF,           64'h0, 0, 1'b0, 64'h1000, 8'hF0, 64'hDEADBEEF00000000, 1'b1, 64'h0};
    vecs[12] = '{OPC_LOAD,  3'b010, 5'd12, 64'h2002, 64'h0,                  RD,    0, 1'b1, 64'h0,    8'h00, 64'h0,                1'b0, 64'h0};
    vecs[13] = '{OPC_STORE, 3'b100, 5'd13, 64'h3000, 64'h55,                 64'h0, 0, 1'b1, 64'h0,    8'h00, 64'h0,                1'b0, 64'h0};
    vecs[14] = '{OPC_LOAD,  3'b111, 5'd14, 64'h2000, 64'h0,                  RD,    0, 1'b1, 64'h0,    8'h00, 64'h0,                1'b0, 64'h0};
    vecs[15] = '{OPC_LOAD,  3'b001, 5'd15, 64'h2001, 64'h0,                  RD,    0, 1'b1, 64'h0,    8'h00, 64'h0,                1'b0, 64'h0};

    drive_idle();
    dst_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst.mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst.mem_be", {56'd0, mem_be}, 64'd0);
    chk("rst.mem_addr", mem_addr, 64'd0);
    chk("rst.dst_valid", {63'd0, dst_valid}, 64'd0);
    chk("rst.dst_rd", dst_rd, 64'd0);
    chk("rst.dst_fault", {63'd0, dst_fault}, 64'd0);
    chk("rst.src_ready", {63'd0, src_ready}, 64'd1);

    // Pass-through, three back-to-back ops
    for (int k = 0; k < 3; k++) begin
      src_valid = 1'b1; src_opcode = OPC_OP; src_rd_addr = 5'd5;
      src_rd = 64'h1234 + 64'(k);
      #1 chk($sformatf("pt%0d.src_ready", k), {63'd0, src_ready}, 64'd1);
      @(negedge clk);
      chk($sformatf("pt%0d.dst_valid", k), {63'd0, dst_valid}, 64'd1);
      chk($sformatf("pt%0d.dst_rd", k), dst_rd, 64'h1234 + 64'(k));
      chk($sformatf("pt%0d.dst_fault", k), {63'd0, dst_fault}, 64'd0);
      chk($sformatf("pt%0d.mem_req", k), {63'd0, mem_req}, 64'd0);
    end
    drive_idle();
    @(negedge clk);
    chk("pt.drain", {63'd0, dst_valid}, 64'd0);

    // Vector table
    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Backpressure
    @(negedge clk);
    dst_ready = 1'b0;
    src_valid = 1'b1; src_opcode = OPC_OP; src_rd_addr = 5'd7; src_rd = 64'h55;
    @(negedge clk);
    src_rd = 64'h66; src_rd_addr = 5'd9;
    #1 chk("bp.src_ready_low", {63'd0, src_ready}, 64'd0);
    chk("bp.dst_rd", dst_rd, 64'h55);
    @(negedge clk);
    chk("bp.dst_valid_hold", {63'd0, dst_valid}, 64'd1);
    chk("bp.dst_rd_hold", dst_rd, 64'h55);
    chk("bp.dst_rd_addr_hold", {59'd0, dst_rd_addr}, 64'd7);
    dst_ready = 1'b1;
    #1 chk("bp.src_ready_high", {63'd0, src_ready}, 64'd1);
    @(negedge clk);
    drive_idle();
    chk("bp.dst_valid_new", {63'd0, dst_valid}, 64'd1);
    chk("bp.dst_rd_new", dst_rd, 64'h66);
    @(negedge clk);
    chk("bp.drain", {63'd0, dst_valid}, 64'd0);

    // Reset while a bus transaction is pending
    src_valid = 1'b1; src_opcode = OPC_LOAD; src_funct3 = 3'b011;
    src_rd_addr = 5'd3; src_mem_addr = 64'h4000;
    @(negedge clk);
    drive_idle();
    chk("rb.mem_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb.mem_req_low", {63'd0, mem_req}, 64'd0);
    chk("rb.dst_valid_low", {63'd0, dst_valid}, 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("rb.ack_ignored_valid", {63'd0, dst_valid}, 64'd0);
    chk("rb.ack_ignored_req", {63'd0, mem_req}, 64'd0);
    chk("rb.src_ready", {63'd0, src_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
